// File: rtl/stratixiii_lvds_rx_word_aligner.sv
// Per-channel LVDS word aligner: bitslips the receiver until the training pattern
// repeats match_count times in a row, then holds lock and watches for alignment loss.
//
// state  | meaning
// IDLE   | bitslip counter held in reset, waiting for rx_dpa_locked
// CHECK  | comparing words, counting consecutive matches
// SLIP   | one-cycle bitslip pulse to the receiver
// WAIT   | letting the receiver settle after a slip, rx_out ignored
// LOCKED | aligned, counting consecutive mismatches
// FAIL   | attempt exhausted, waiting for align_start
module stratixiii_lvds_rx_word_aligner #(
  parameter int          deserialization_factor = 4,
  parameter logic [43:0] training_pattern       = 44'h0000000000F,
  parameter int          match_count            = 4,
  parameter int          slip_wait_cycles       = 3,
  parameter int          max_slip_attempts      = 8,
  parameter int          loss_mismatch_count    = 3
) (
  input  logic                              rx_slowclk,
  input  logic                              rx_reset_n,
  input  logic [deserialization_factor-1:0] rx_out,
  input  logic                              rx_dpa_locked,
  input  logic                              rx_cda_max,
  input  logic                              align_start,
  output logic                              rx_channel_data_align,
  output logic                              rx_cda_reset,
  output logic                              align_locked,
  output logic                              align_fail,
  output logic [5:0]                        slip_count,
  output logic [deserialization_factor-1:0] aligned_data,
  output logic                              aligned_valid
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_SLIP   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;
  localparam logic [2:0] ST_FAIL   = 3'd5;

  localparam logic [deserialization_factor-1:0] pattern_w =
    training_pattern[deserialization_factor-1:0];
  localparam logic [3:0] match_tc = 4'(match_count - 1);
  localparam logic [3:0] loss_tc  = 4'(loss_mismatch_count - 1);
  localparam logic [3:0] wait_ld  = 4'(slip_wait_cycles - 1);
  localparam logic [5:0] slip_max = 6'(max_slip_attempts);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       match_q;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;
  logic [3:0] wait_cnt;
  logic       rollover_seen;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (rx_dpa_locked) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (match_q) begin
          if (match_cnt == match_tc) state_nxt = ST_LOCKED;
        end else if (slip_count == slip_max) begin
          state_nxt = ST_FAIL;
        end else begin
          state_nxt = ST_SLIP;
        end
      end
      ST_SLIP: begin
        if (rx_cda_max && rollover_seen) state_nxt = ST_FAIL;
        else                             state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (rx_cda_max && rollover_seen) state_nxt = ST_FAIL;
        else if (wait_cnt == 4'd0)       state_nxt = ST_CHECK;
      end
      ST_LOCKED: if (!match_q && miss_cnt == loss_tc) state_nxt = ST_CHECK;
      ST_FAIL:   state_nxt = ST_FAIL;
      default:   state_nxt = ST_IDLE;
    endcase
    // Restart and DPA loss override every other transition.
    if (align_start || (!rx_dpa_locked && state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  always_ff @(posedge rx_slowclk) begin
    if (!rx_reset_n) begin
      state                 <= ST_IDLE;
      match_q               <= 1'b0;
      match_cnt             <= 4'd0;
      miss_cnt              <= 4'd0;
      wait_cnt              <= 4'd0;
      rollover_seen         <= 1'b0;
      slip_count            <= 6'd0;
      rx_channel_data_align <= 1'b0;
      rx_cda_reset          <= 1'b1;
      align_locked          <= 1'b0;
      align_fail            <= 1'b0;
      aligned_data          <= '0;
      aligned_valid         <= 1'b0;
    end else begin
      state        <= state_nxt;
      match_q      <= (rx_out == pattern_w);
      aligned_data <= rx_out;

      // Outputs are decoded from the next state so they line up with the state register.
      rx_channel_data_align <= (state_nxt == ST_SLIP);
      rx_cda_reset          <= (state_nxt == ST_IDLE);
      align_locked          <= (state_nxt == ST_LOCKED);
      aligned_valid         <= (state_nxt == ST_LOCKED);
      align_fail            <= (state_nxt == ST_FAIL);

      if (state == ST_CHECK && state_nxt == ST_CHECK)
        match_cnt <= match_q ? match_cnt + 4'd1 : 4'd0;
      else
        match_cnt <= 4'd0;

      if (state == ST_LOCKED && state_nxt == ST_LOCKED)
        miss_cnt <= match_q ? 4'd0 : miss_cnt + 4'd1;
      else
        miss_cnt <= 4'd0;

      if (state_nxt == ST_IDLE)
        wait_cnt <= 4'd0;
      else if (state == ST_SLIP)
        wait_cnt <= wait_ld;
      else if (state == ST_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;

      if (state_nxt == ST_IDLE)
        rollover_seen <= 1'b0;
      else if ((state == ST_SLIP || state == ST_WAIT) && rx_cda_max)
        rollover_seen <= 1'b1;

      if (state_nxt == ST_IDLE)
        slip_count <= 6'd0;
      else if (state_nxt == ST_SLIP && state != ST_SLIP && slip_count != 6'd63)
        slip_count <= slip_count + 6'd1;
    end
  end

endmodule

// File: tb/tb_stratixiii_lvds_rx_word_aligner.sv
// Directed bench for the LVDS word aligner with a rotating-word receiver model.
// The pattern 4'h3 is used because all four of its bit rotations are distinct.
module tb_stratixiii_lvds_rx_word_aligner;

  logic       rx_slowclk = 1'b0;
  logic       rx_reset_n;
  logic [3:0] rx_out;
  logic       rx_dpa_locked;
  logic       rx_cda_max;
  logic       align_start;
  logic       rx_channel_data_align;
  logic       rx_cda_reset;
  logic       align_locked;
  logic       align_fail;
  logic [5:0] slip_count;
  logic [3:0] aligned_data;
  logic       aligned_valid;

  logic [3:0] base_word;
  logic [1:0] rot0;
  logic [1:0] rsel;
  logic       model_clr;
  logic       cda_max_en;
  int         nslip;
  int         cyc;
  int         last_pulse;
  int         min_gap;
  logic       prev_cda;
  logic       dbl_pulse;

  int checks = 0;
  int errors = 0;

  always #5 rx_slowclk = ~rx_slowclk;

  stratixiii_lvds_rx_word_aligner #(
    .deserialization_factor(4),
    .training_pattern      (44'h3),
    .match_count           (4),
    .slip_wait_cycles      (3),
    .max_slip_attempts     (8),
    .loss_mismatch_count   (3)
  ) dut (
    .rx_slowclk           (rx_slowclk),
    .rx_reset_n           (rx_reset_n),
    .rx_out               (rx_out),
    .rx_dpa_locked        (rx_dpa_locked),
    .rx_cda_max           (rx_cda_max),
    .align_start          (align_start),
    .rx_channel_data_align(rx_channel_data_align),
    .rx_cda_reset         (rx_cda_reset),
    .align_locked         (align_locked),
    .align_fail           (align_fail),
    .slip_count           (slip_count),
    .aligned_data         (aligned_data),
    .aligned_valid        (aligned_valid)
  );

  function automatic logic [3:0] rotl(input logic [3:0] w, input logic [1:0] r);
    logic [7:0] t;
    t = {w, w} << r;
    return t[7:4];
  endfunction

  // Receiver: each bitslip pulse rotates the delivered word by one more bit.
  assign rsel       = rot0 + nslip[1:0];
  assign rx_out     = rotl(base_word, rsel);
  assign rx_cda_max = cda_max_en & rx_channel_data_align & (nslip[1:0] == 2'd3);

  always @(posedge rx_slowclk) begin
    cyc      <= cyc + 1;
    prev_cda <= rx_channel_data_align;
    if (model_clr) begin
      nslip      <= 0;
      last_pulse <= 0;
      min_gap    <= 99;
      dbl_pulse  <= 1'b0;
    end else if (rx_channel_data_align) begin
      nslip      <= nslip + 1;
      last_pulse <= cyc;
      if (nslip != 0 && (cyc - last_pulse) < min_gap) min_gap <= cyc - last_pulse;
      if (prev_cda) dbl_pulse <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rx_slowclk);
  endtask

  task automatic clear_model();
    model_clr = 1'b1;
    tick(1);
    model_clr = 1'b0;
  endtask

  initial begin
    int n;
    cyc = 0; prev_cda = 1'b0;
    nslip = 0; last_pulse = 0; min_gap = 99; dbl_pulse = 1'b0;
    rx_reset_n = 1'b0; rx_dpa_locked = 1'b0; align_start = 1'b0;
    base_word = 4'h3; rot0 = 2'd0; model_clr = 1'b0; cda_max_en = 1'b0;
    tick(3);

    chk("rst_cda_reset", rx_cda_reset, 1);
    chk("rst_cda", rx_channel_data_align, 0);
    chk("rst_locked", align_locked, 0);
    chk("rst_fail", align_fail, 0);
    chk("rst_slip_count", slip_count, 0);
    chk("rst_valid", aligned_valid, 0);
    chk("rst_data", aligned_data, 0);

    rx_reset_n = 1'b1;
    clear_model();
    tick(2);
    chk("idle_cda_reset", rx_cda_reset, 1);

    // Pattern present from the start.
    rx_dpa_locked = 1'b1;
    tick(1);
    chk("t1_cda_reset_low", rx_cda_reset, 0);
    tick(2);
    chk("t1_not_locked_early", align_locked, 0);
    tick(3);
    chk("t1_locked", align_locked, 1);
    chk("t1_valid", aligned_valid, 1);
    chk("t1_slip_count", slip_count, 0);
    chk("t1_no_pulses", nslip, 0);
    chk("t1_data", aligned_data, 4'h3);

    // Receiver starts two bit positions off.
    rx_dpa_locked = 1'b0;
    tick(1);
    chk("t2_idle", rx_cda_reset, 1);
    rot0 = 2'd2;
    clear_model();
    rx_dpa_locked = 1'b1;
    n = 0;
    while (!align_locked && n < 40) begin tick(1); n++; end
    chk("t2_lock_in_budget", align_locked, 1);
    chk("t2_pulses", nslip, 2);
    chk("t2_slip_count", slip_count, 2);
    chk("t2_gap", min_gap, 5);
    chk("t2_single_width", dbl_pulse, 0);
    chk("t2_data", aligned_data, 4'h3);

    // Scattered mismatches must not drop lock.
    base_word = 4'h0; tick(1);
    base_word = 4'h0; tick(1);
    base_word = 4'h3; tick(1);
    chk("t4_hold_a", align_locked, 1);
    base_word = 4'h0; tick(1);
    base_word = 4'h0; tick(1);
    chk("t4_hold_b", align_locked, 1);
    base_word = 4'h3; tick(3);
    chk("t4_hold_c", align_locked, 1);

    // Three consecutive mismatches drop lock and slipping resumes.
    base_word = 4'h0;
    tick(3);
    chk("t4_still_locked", align_locked, 1);
    tick(1);
    chk("t4_lost", align_locked, 0);
    chk("t4_valid_low", aligned_valid, 0);
    chk("t4_count_kept", slip_count, 2);
    tick(1);
    chk("t4_reslip", rx_channel_data_align, 1);
    chk("t4_count_inc", slip_count, 3);
    tick(1);
    chk("t4_pulse_end", rx_channel_data_align, 0);

    // DPA loss while waiting after a slip.
    rx_dpa_locked = 1'b0;
    tick(1);
    chk("t5_cda_reset", rx_cda_reset, 1);
    chk("t5_slip_count", slip_count, 0);
    chk("t5_cda", rx_channel_data_align, 0);

    // Pattern absent everywhere; rollover reported every fourth slip.
    base_word = 4'h5; rot0 = 2'd0;
    clear_model();
    cda_max_en = 1'b1;
    rx_dpa_locked = 1'b1;
    n = 0;
    while (!align_fail && n < 200) begin tick(1); n++; end
    chk("t3_fail_in_budget", align_fail, 1);
    chk("t3_slip_count", slip_count, 8);
    chk("t3_pulses", nslip, 8);
    chk("t3_single_width", dbl_pulse, 0);
    tick(20);
    chk("t3_no_more_pulses", nslip, 8);
    chk("t3_fail_held", align_fail, 1);
    align_start = 1'b1;
    tick(1);
    align_start = 1'b0;
    chk("t3_restart_fail", align_fail, 0);
    chk("t3_restart_cda_reset", rx_cda_reset, 1);
    chk("t3_restart_count", slip_count, 0);

    // Reset asserted together with a slip pulse and align_start.
    rx_dpa_locked = 1'b0;
    cda_max_en = 1'b0;
    base_word = 4'h0;
    tick(1);
    clear_model();
    rx_dpa_locked = 1'b1;
    tick(2);
    chk("t6_pulse", rx_channel_data_align, 1);
    chk("t6_pre_count", slip_count, 1);
    rx_reset_n = 1'b0;
    align_start = 1'b1;
    tick(1);
    chk("t6_cda", rx_channel_data_align, 0);
    chk("t6_cda_reset", rx_cda_reset, 1);
    chk("t6_locked", align_locked, 0);
    chk("t6_fail", align_fail, 0);
    chk("t6_count", slip_count, 0);
    chk("t6_valid", aligned_valid, 0);
    chk("t6_data", aligned_data, 0);
    rx_reset_n = 1'b1;
    align_start = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
